// File: rtl/serial_alu_seq_if.sv
// ============================================================================
// Module   : serial_alu_seq_if
// Brief    : Request/response bundle between a client and serial_alu_seq.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface serial_alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [1:0]       op_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;

  modport master (
    output start, a_in, b_in, op_in,
    input  busy, done, result, carry_out
  );

  modport slave (
    input  start, a_in, b_in, op_in,
    output busy, done, result, carry_out
  );
endinterface

`default_nettype wire

// File: rtl/serial_alu_seq.sv
// ============================================================================
// Module   : serial_alu_seq
// Brief    : Bit-serial sequencer feeding a 1-bit ALU slice LSB first and
//            assembling its result bits into a word.
// Revision : 1.0
// ============================================================================
`default_nettype none

module serial_alu_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  serial_alu_seq_if.slave  bus,
  output      logic        slice_a,
  output      logic        slice_b,
  output      logic        slice_cin,
  output      logic [1:0]  slice_op,
  input  wire logic        slice_result,
  input  wire logic        slice_cout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [1:0]       C_OP_ADD = 2'b01;
  localparam logic [CNT_W-1:0] C_LAST   = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       op_q, op_d;
  logic             carry_q, carry_d;
  logic             carry_out_q, carry_out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             w_shift;
  logic             w_add;

  assign w_shift = (state_q == S_SHIFT);
  assign w_add   = (op_q == C_OP_ADD);

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    result_d    = result_q;
    count_d     = count_q;
    op_d        = op_q;
    carry_d     = carry_q;
    carry_out_d = carry_out_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d         = bus.a_in;
          b_d         = bus.b_in;
          op_d        = bus.op_in;
          carry_d     = 1'b0;
          count_d     = '0;
          result_d    = '0;
          carry_out_d = 1'b0;
          busy_d      = 1'b1;
          state_d     = S_SHIFT;
        end
      end
      S_SHIFT: begin
        result_d = {slice_result, result_q[WIDTH-1:1]};
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        carry_d  = w_add ? slice_cout : 1'b0;
        count_d  = count_q + 1'b1;
        // Last bit lands on this edge; the final carry is latched for the report.
        if (count_q == C_LAST) begin
          carry_out_d = carry_d;
          done_d      = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      count_q     <= '0;
      op_q        <= '0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      result_q    <= result_d;
      count_q     <= count_d;
      op_q        <= op_d;
      carry_q     <= carry_d;
      carry_out_q <= carry_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.carry_out = carry_out_q;

  // Operand bits reach the slice only while shifting so an idle slice sees zeros.
  assign slice_a   = w_shift & a_q[0];
  assign slice_b   = w_shift & b_q[0];
  assign slice_cin = w_shift & w_add & carry_q;
  assign slice_op  = op_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_alu_seq.sv
// ============================================================================
// Module   : tb_serial_alu_seq
// Brief    : Scoreboard bench for serial_alu_seq with a 1-bit ALU slice model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_serial_alu_seq;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_alu_seq_if #(.WIDTH(WIDTH)) bus ();

  logic       slice_a, slice_b, slice_cin, slice_result, slice_cout;
  logic [1:0] slice_op;

  serial_alu_seq #(.WIDTH(WIDTH), .CNT_W(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .slice_a      (slice_a),
    .slice_b      (slice_b),
    .slice_cin    (slice_cin),
    .slice_op     (slice_op),
    .slice_result (slice_result),
    .slice_cout   (slice_cout)
  );

  always_comb begin
    slice_result = 1'b0;
    slice_cout   = 1'b0;
    case (slice_op)
      2'b00: slice_result = slice_a;
      2'b01: begin
        slice_result = slice_a ^ slice_b ^ slice_cin;
        slice_cout   = (slice_a & slice_b) | (slice_a & slice_cin) | (slice_b & slice_cin);
      end
      2'b10: slice_result = slice_a & slice_b;
      default: slice_result = ~slice_a;
    endcase
  end

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             cy;
    int               due;
  } exp_t;

  exp_t             sb_q[$];
  int               tests = 0;
  int               fails = 0;
  int               cyc = 0;
  int               free_at = 0;
  int               last_e = -100;
  logic [WIDTH-1:0] last_res = '0;
  logic             last_cy = 1'b0;
  logic [1:0]       cur_op = 2'b00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t ref_model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                     input logic [1:0] op, input int due);
    exp_t e;
    int unsigned sum;
    e.cy  = 1'b0;
    e.due = due;
    case (op)
      2'b00: e.res = a;
      2'b01: begin
        sum   = int'(a) + int'(b);
        e.res = WIDTH'(sum % (1 << WIDTH));
        e.cy  = (sum >= (1 << WIDTH));
      end
      2'b10: e.res = a & b;
      default: e.res = ~a;
    endcase
    return e;
  endfunction

  // One cycle of stimulus; the model decides whether the upcoming edge accepts start.
  task automatic drive(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [1:0] op, input logic st);
    exp_t e;
    int   edge_n;
    @(negedge clk);
    #2;
    bus.start = st;
    bus.a_in  = a;
    bus.b_in  = b;
    bus.op_in = op;
    edge_n    = cyc + 1;
    if (st && edge_n >= free_at) begin
      e = ref_model(a, b, op, edge_n + WIDTH);
      sb_q.push_back(e);
      last_e   = edge_n;
      free_at  = edge_n + WIDTH + 2;
      cur_op   = op;
      last_res = e.res;
      last_cy  = e.cy;
    end
  endtask

  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [1:0] op);
    drive(a, b, op, 1'b1);
    for (int i = 0; i < WIDTH + 2; i++)
      drive(WIDTH'($urandom), WIDTH'($urandom), 2'($urandom), 1'b0);
  endtask

  exp_t mon_e;
  logic mon_busy_exp;

  always @(negedge clk) begin
    if (rst_n) begin
      mon_busy_exp = (cyc >= last_e) && (cyc <= last_e + WIDTH);
      check("busy", 32'(bus.busy), 32'(mon_busy_exp));
      if (bus.done) begin
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc);
        end else begin
          mon_e = sb_q.pop_front();
          check("result", 32'(bus.result), 32'(mon_e.res));
          check("carry_out", 32'(bus.carry_out), 32'(mon_e.cy));
          check("done_cycle", 32'(cyc), 32'(mon_e.due));
        end
      end else if (sb_q.size() > 0 && cyc > sb_q[0].due) begin
        mon_e = sb_q.pop_front();
        tests++;
        fails++;
        $display("FAIL done_timeout: got no done by cycle %0d expected done at %0d", cyc, mon_e.due);
      end
      if (cyc > last_e + WIDTH) begin
        check("result_hold", 32'(bus.result), 32'(last_res));
        check("carry_hold", 32'(bus.carry_out), 32'(last_cy));
      end
      if (cur_op != 2'b01)
        check("slice_cin_nonadd", 32'(slice_cin), 32'd0);
    end
  end

  task automatic check_reset_outputs();
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_carry", 32'(bus.carry_out), 32'd0);
    check("rst_slice", {28'd0, slice_a, slice_b, slice_cin, |slice_op}, 32'd0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.a_in  = '0;
    bus.b_in  = '0;
    bus.op_in = 2'b00;
    #3;
    check_reset_outputs();
    @(negedge clk);
    #2 rst_n = 1'b1;

    run_op(8'h5A, 8'h3C, 2'b01);
    run_op(8'hFF, 8'h01, 2'b01);
    run_op(8'hF0, 8'h3C, 2'b10);
    run_op(8'hA5, 8'h00, 2'b11);
    run_op(8'hC3, 8'hFF, 2'b00);

    // A second start while busy must not disturb the running add.
    drive(8'h11, 8'h47, 2'b01, 1'b1);
    drive(8'h00, 8'h00, 2'b00, 1'b0);
    drive(8'h22, 8'h99, 2'b10, 1'b1);
    for (int i = 0; i < WIDTH + 2; i++) drive(8'h00, 8'h00, 2'b00, 1'b0);

    // Reset in the middle of a shift aborts the operation.
    drive(8'h6B, 8'h2D, 2'b01, 1'b1);
    for (int i = 0; i < 4; i++) drive(8'h00, 8'h00, 2'b00, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    sb_q.delete();
    last_e   = -100;
    free_at  = 0;
    last_res = '0;
    last_cy  = 1'b0;
    cur_op   = 2'b00;
    @(negedge clk);
    #2 rst_n = 1'b1;
    run_op(8'h01, 8'h01, 2'b01);

    // Continuous start retriggers every WIDTH+2 cycles.
    for (int i = 0; i < 30; i++) drive(8'h37, 8'hE5, 2'b01, 1'b1);
    for (int i = 0; i < WIDTH + 2; i++) drive(8'h00, 8'h00, 2'b00, 1'b0);

    for (int i = 0; i < 12; i++)
      run_op(WIDTH'($urandom), WIDTH'($urandom), 2'($urandom));

    // Random start density exercises back-to-back and DONE-cycle requests.
    for (int i = 0; i < 300; i++)
      drive(WIDTH'($urandom), WIDTH'($urandom), 2'($urandom), 1'($urandom_range(0, 3) != 0));
    for (int i = 0; i < WIDTH + 4; i++) drive(8'h00, 8'h00, 2'b00, 1'b0);

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

`default_nettype wire
